accel_interface: RTL and testbench
==================================

# accel_interface

Front-end stage directly upstream of `Accel`: consumes one 18-bit word stream per job, latches the job header into the configuration ports `Accel` samples, and writes the payload (image + filter words) into accelerator memory through `interface_write_*`. It then releases the accelerator from reset, waits for `accel_done`, counts run cycles, and reports job completion. Job jobs are back-to-back; each new header starts a fresh job.

## Interface
- `HDR_WORDS`, default 10: header length in words (fixed; indices below).
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_data`  in  18  stream word.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  block accepts word this cycle; transfer when `in_valid & in_ready`.
- `image_dim`  out  8  header word 0 [7:0].
- `image_depth`  out  9  header word 1 [8:0].
- `image_memory_offset`, `filter_memory_offset`, `output_memory_offset`  out  16 each  header words 2, 3, 4 [15:0].
- `filter_halfsize`  out  2  header word 5 [1:0].
- `filter_stride`  out  3  header word 5 [4:2].
- `filter_length`  out  13  header word 6 [12:0].
- `filter_bias`  out  18  header word 7.
- `interface_write_addr`  out  16  payload write address.
- `interface_write_data`  out  18  payload write data.
- `interface_write_en`  out  1  payload write strobe.
- `accel_rst`  out  1  held-reset for `Accel`; OR'd into its `rst`.
- `accel_done`  in  1  completion from `Accel`.
- `job_done`  out  1  one-cycle pulse at job end.
- `job_error`  out  1  sticky: last header rejected; cleared by next accepted header.
- `run_cycles`  out  32  cycles spent in RUN for the last job.

## Operation
- States: HEADER, LOAD, SKIP, RUN, DONE. Reset state HEADER.
- HEADER: `in_ready`=1; word i (0..9) latched into header register i; header counter increments per transfer. Word 8 = payload length `plen[15:0]`, word 9 = payload base `pbase[15:0]`.
- Header check on the transfer of word 9: reject if `image_dim`==0, stride==0, or `filter_length`==0. Reject -> `job_error`=1, go SKIP. Accept -> `job_error`=0; go LOAD if `plen`≠0, else RUN.
- LOAD: `in_ready`=1; transfer k writes `pbase+k` (16-bit wrap, modulo 2^16) with the word. After `plen` transfers -> RUN.
- SKIP: `in_ready`=1; discards `plen` words without writing, then -> HEADER (`plen`==0 -> HEADER immediately). No `job_done`.
- RUN: `in_ready`=0; `accel_rst`=0; `run_cycles` cleared on entry, +1 per RUN cycle, saturates at 2^32-1. `accel_done` ignored in the first RUN cycle (`Accel` still leaving reset); sampled from the second onward; high -> DONE.
- DONE: one cycle; `job_done`=1, `accel_rst`=1, `in_ready`=0; -> HEADER.
- `accel_rst`=1 in every state except RUN.
- Config outputs hold last accepted header values through RUN and DONE; overwritten word by word during the next HEADER (`Accel` is in reset, so that is harmless).

## Timing
- Reset values: all config outputs 0, `interface_write_*` 0, `in_ready` 0 during reset and 1 in the first cycle after it, `accel_rst` 1, `job_done` 0, `job_error` 0, `run_cycles` 0, header/payload counters 0.
- `in_ready` is decoded from state register only (no combinational path from `in_valid`).
- Payload write: registered, one cycle after the accepting edge; `interface_write_en` high exactly one cycle per transfer.
- Last LOAD transfer at edge t: write at t+1, RUN (`accel_rst`=0) from t+1; the memory write lands the same edge `Accel` leaves reset, and the first memory read is ≥1 cycle later.
- `accel_done` seen high at edge t (second RUN cycle or later): DONE during t..t+1, `job_done` pulse, `run_cycles` frozen at its value in DONE.
- Stalls (`in_valid`=0) in HEADER/LOAD/SKIP: no state change, no write.
- Async `rst` mid-job: immediate return to reset values; partial payload stays in memory; next word is treated as header word 0.

## Structure
- Package `accel_interface_pkg`: state encoding, header word indices (`HDR_DIM`..`HDR_PBASE`), `HDR_WORDS`, field bit positions for word 5.
- Sub-module `accel_interface_header`: the header register file, index decode and validity check; the top holds FSM, payload counter/address, and run counter.

## Test plan
- Header {dim 8, depth 3, offs 0x0000/0x00C0/0x0100, halfsize 1, stride 1, flen 27, bias 5, plen 4, pbase 0x0010} + payload A,B,C,D -> writes 0x0010..0x0013 = A..D one cycle after each transfer; RUN begins one cycle after D.
- Same job, `accel_done` forced high from RUN start, dropping after 1 cycle -> ignored; forced high at 50th RUN cycle -> `job_done` pulse, `run_cycles`=50.
- pbase 0xFFFE, plen 4 -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- stride 0, plen 3 -> `job_error`=1, 3 words consumed, no writes, no `job_done`; next valid header clears `job_error`.
- plen 0 -> RUN directly after word 9; `in_valid` toggled randomly in LOAD -> write count equals transfer count.
- `rst` pulsed during LOAD word 2 -> all outputs return to reset values, `accel_rst`=1; next header is parsed from word 0.

Source files
------------

// File: rtl/accel_interface_pkg.sv
// rtl/accel_interface_pkg.sv - shared types and header layout for accel_interface
package accel_interface_pkg;

  // Job sequencing states
  typedef enum logic [2:0] {
    ST_HEADER = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SKIP   = 3'd2,
    ST_RUN    = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam int HDR_WORDS = 10;
  localparam int HDR_CNT_W = 4;

  // Header word indices
  localparam logic [HDR_CNT_W-1:0] HDR_DIM     = 4'd0;
  localparam logic [HDR_CNT_W-1:0] HDR_DEPTH   = 4'd1;
  localparam logic [HDR_CNT_W-1:0] HDR_IMG_OFF = 4'd2;
  localparam logic [HDR_CNT_W-1:0] HDR_FLT_OFF = 4'd3;
  localparam logic [HDR_CNT_W-1:0] HDR_OUT_OFF = 4'd4;
  localparam logic [HDR_CNT_W-1:0] HDR_FILTER  = 4'd5;
  localparam logic [HDR_CNT_W-1:0] HDR_FLEN    = 4'd6;
  localparam logic [HDR_CNT_W-1:0] HDR_BIAS    = 4'd7;
  localparam logic [HDR_CNT_W-1:0] HDR_PLEN    = 4'd8;
  localparam logic [HDR_CNT_W-1:0] HDR_PBASE   = 4'd9;

  // Field positions inside the filter word
  localparam int F_HALFSIZE_LSB = 0;
  localparam int F_HALFSIZE_MSB = 1;
  localparam int F_STRIDE_LSB   = 2;
  localparam int F_STRIDE_MSB   = 4;

endpackage

// File: rtl/accel_interface_header.sv
// rtl/accel_interface_header.sv - header register file, index decode and validity check
module accel_interface_header
  import accel_interface_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_wr,
  input  logic [HDR_CNT_W-1:0] i_idx,
  input  logic [17:0]          i_data,
  output logic [7:0]           o_image_dim,
  output logic [8:0]           o_image_depth,
  output logic [15:0]          o_image_memory_offset,
  output logic [15:0]          o_filter_memory_offset,
  output logic [15:0]          o_output_memory_offset,
  output logic [1:0]           o_filter_halfsize,
  output logic [2:0]           o_filter_stride,
  output logic [12:0]          o_filter_length,
  output logic [17:0]          o_filter_bias,
  output logic [15:0]          o_plen,
  output logic [15:0]          o_pbase,
  output logic                 o_valid
);

  logic [7:0]  r_dim;
  logic [8:0]  r_depth;
  logic [15:0] r_img_off;
  logic [15:0] r_flt_off;
  logic [15:0] r_out_off;
  logic [1:0]  r_halfsize;
  logic [2:0]  r_stride;
  logic [12:0] r_flen;
  logic [17:0] r_bias;
  logic [15:0] r_plen;
  logic [15:0] r_pbase;

  // Latch each header word into its field as it arrives
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_dim      <= '0;
      r_depth    <= '0;
      r_img_off  <= '0;
      r_flt_off  <= '0;
      r_out_off  <= '0;
      r_halfsize <= '0;
      r_stride   <= '0;
      r_flen     <= '0;
      r_bias     <= '0;
      r_plen     <= '0;
      r_pbase    <= '0;
    end else if (i_wr) begin
      case (i_idx)
        HDR_DIM:     r_dim     <= i_data[7:0];
        HDR_DEPTH:   r_depth   <= i_data[8:0];
        HDR_IMG_OFF: r_img_off <= i_data[15:0];
        HDR_FLT_OFF: r_flt_off <= i_data[15:0];
        HDR_OUT_OFF: r_out_off <= i_data[15:0];
        HDR_FILTER: begin
          r_halfsize <= i_data[F_HALFSIZE_MSB:F_HALFSIZE_LSB];
          r_stride   <= i_data[F_STRIDE_MSB:F_STRIDE_LSB];
        end
        HDR_FLEN:    r_flen    <= i_data[12:0];
        HDR_BIAS:    r_bias    <= i_data;
        HDR_PLEN:    r_plen    <= i_data[15:0];
        HDR_PBASE:   r_pbase   <= i_data[15:0];
        default: ;
      endcase
    end
  end

  // The checked fields all precede the final word, so they are stable when it arrives
  assign o_valid = (r_dim != '0) && (r_stride != '0) && (r_flen != '0);

  assign o_image_dim            = r_dim;
  assign o_image_depth          = r_depth;
  assign o_image_memory_offset  = r_img_off;
  assign o_filter_memory_offset = r_flt_off;
  assign o_output_memory_offset = r_out_off;
  assign o_filter_halfsize      = r_halfsize;
  assign o_filter_stride        = r_stride;
  assign o_filter_length        = r_flen;
  assign o_filter_bias          = r_bias;
  assign o_plen                 = r_plen;
  assign o_pbase                = r_pbase;

endmodule

// File: rtl/accel_interface.sv
// rtl/accel_interface.sv - job front-end: header parse, payload load, accelerator run control
module accel_interface
  import accel_interface_pkg::*;
#(
  parameter int HDR_WORDS = accel_interface_pkg::HDR_WORDS
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [17:0] i_in_data,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  output logic [7:0]  o_image_dim,
  output logic [8:0]  o_image_depth,
  output logic [15:0] o_image_memory_offset,
  output logic [15:0] o_filter_memory_offset,
  output logic [15:0] o_output_memory_offset,
  output logic [1:0]  o_filter_halfsize,
  output logic [2:0]  o_filter_stride,
  output logic [12:0] o_filter_length,
  output logic [17:0] o_filter_bias,
  output logic [15:0] o_interface_write_addr,
  output logic [17:0] o_interface_write_data,
  output logic        o_interface_write_en,
  output logic        o_accel_rst,
  input  logic        i_accel_done,
  output logic        o_job_done,
  output logic        o_job_error,
  output logic [31:0] o_run_cycles
);

  localparam logic [HDR_CNT_W-1:0] LAST_IDX = HDR_CNT_W'(HDR_WORDS - 1);

  state_t r_state;
  state_t w_next_state;

  logic [HDR_CNT_W-1:0] r_hdr_cnt;
  logic [15:0]          r_pay_cnt;
  logic [31:0]          r_run_cycles;
  logic                 r_job_error;
  logic                 r_wr_en;
  logic [15:0]          r_wr_addr;
  logic [17:0]          r_wr_data;

  logic        w_ready;
  logic        w_xfer;
  logic        w_hdr_last;
  logic        w_pay_last;
  logic        w_hdr_valid;
  logic [15:0] w_plen;
  logic [15:0] w_pbase;

  // Ready is a pure state decode; reset masks it so nothing is accepted while held
  assign w_ready    = (r_state == ST_HEADER) || (r_state == ST_LOAD) || (r_state == ST_SKIP);
  assign w_xfer     = i_in_valid & w_ready;
  assign w_hdr_last = (r_state == ST_HEADER) & w_xfer & (r_hdr_cnt == LAST_IDX);
  assign w_pay_last = w_xfer & ((r_pay_cnt + 16'd1) == w_plen);

  accel_interface_header u_header (
    .i_clk                  (i_clk),
    .i_rst                  (i_rst),
    .i_wr                   ((r_state == ST_HEADER) & w_xfer),
    .i_idx                  (r_hdr_cnt),
    .i_data                 (i_in_data),
    .o_image_dim            (o_image_dim),
    .o_image_depth          (o_image_depth),
    .o_image_memory_offset  (o_image_memory_offset),
    .o_filter_memory_offset (o_filter_memory_offset),
    .o_output_memory_offset (o_output_memory_offset),
    .o_filter_halfsize      (o_filter_halfsize),
    .o_filter_stride        (o_filter_stride),
    .o_filter_length        (o_filter_length),
    .o_filter_bias          (o_filter_bias),
    .o_plen                 (w_plen),
    .o_pbase                (w_pbase),
    .o_valid                (w_hdr_valid)
  );

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_HEADER;
    else       r_state <= w_next_state;
  end

  // Next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_HEADER: begin
        if (w_hdr_last) begin
          if (!w_hdr_valid)        w_next_state = (w_plen == '0) ? ST_HEADER : ST_SKIP;
          else                     w_next_state = (w_plen == '0) ? ST_RUN : ST_LOAD;
        end
      end
      ST_LOAD:   if (w_pay_last) w_next_state = ST_RUN;
      ST_SKIP:   if (w_pay_last) w_next_state = ST_HEADER;
      // A zero count means this is the first RUN cycle, when done is not yet meaningful
      ST_RUN:    if ((r_run_cycles != '0) && i_accel_done) w_next_state = ST_DONE;
      ST_DONE:   w_next_state = ST_HEADER;
      default:   w_next_state = ST_HEADER;
    endcase
  end

  // Header/payload counters and sticky error flag
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hdr_cnt   <= '0;
      r_pay_cnt   <= '0;
      r_job_error <= 1'b0;
    end else begin
      if ((r_state == ST_HEADER) && w_xfer)
        r_hdr_cnt <= w_hdr_last ? '0 : r_hdr_cnt + 1'b1;
      if (w_hdr_last) begin
        r_pay_cnt   <= '0;
        r_job_error <= ~w_hdr_valid;
      end else if (((r_state == ST_LOAD) || (r_state == ST_SKIP)) && w_xfer) begin
        r_pay_cnt <= w_pay_last ? '0 : r_pay_cnt + 16'd1;
      end
    end
  end

  // Registered payload write port; address wraps naturally in 16 bits
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= (r_state == ST_LOAD) & w_xfer;
      if ((r_state == ST_LOAD) && w_xfer) begin
        r_wr_addr <= w_pbase + r_pay_cnt;
        r_wr_data <= i_in_data;
      end
    end
  end

  // Run-cycle counter: cleared on RUN entry, saturating, frozen outside RUN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_run_cycles <= '0;
    end else if ((w_next_state == ST_RUN) && (r_state != ST_RUN)) begin
      r_run_cycles <= '0;
    end else if ((r_state == ST_RUN) && (r_run_cycles != '1)) begin
      r_run_cycles <= r_run_cycles + 32'd1;
    end
  end

  assign o_in_ready             = w_ready & ~i_rst;
  assign o_accel_rst            = (r_state != ST_RUN);
  assign o_job_done             = (r_state == ST_DONE);
  assign o_job_error            = r_job_error;
  assign o_run_cycles           = r_run_cycles;
  assign o_interface_write_en   = r_wr_en;
  assign o_interface_write_addr = r_wr_addr;
  assign o_interface_write_data = r_wr_data;

endmodule

// File: tb/tb_accel_interface.sv
// tb/tb_accel_interface.sv - randomized self-checking bench for accel_interface
module tb_accel_interface;

  logic        i_clk;
  logic        i_rst;
  logic [17:0] i_in_data;
  logic        i_in_valid;
  logic        o_in_ready;
  logic [7:0]  o_image_dim;
  logic [8:0]  o_image_depth;
  logic [15:0] o_image_memory_offset;
  logic [15:0] o_filter_memory_offset;
  logic [15:0] o_output_memory_offset;
  logic [1:0]  o_filter_halfsize;
  logic [2:0]  o_filter_stride;
  logic [12:0] o_filter_length;
  logic [17:0] o_filter_bias;
  logic [15:0] o_interface_write_addr;
  logic [17:0] o_interface_write_data;
  logic        o_interface_write_en;
  logic        o_accel_rst;
  logic        i_accel_done;
  logic        o_job_done;
  logic        o_job_error;
  logic [31:0] o_run_cycles;

  int n_checks = 0;
  int n_err    = 0;
  int n_done   = 0;
  int n_wr     = 0;
  logic [33:0] exp_q[$];

  accel_interface dut (
    .i_clk                  (i_clk),
    .i_rst                  (i_rst),
    .i_in_data              (i_in_data),
    .i_in_valid             (i_in_valid),
    .o_in_ready             (o_in_ready),
    .o_image_dim            (o_image_dim),
    .o_image_depth          (o_image_depth),
    .o_image_memory_offset  (o_image_memory_offset),
    .o_filter_memory_offset (o_filter_memory_offset),
    .o_output_memory_offset (o_output_memory_offset),
    .o_filter_halfsize      (o_filter_halfsize),
    .o_filter_stride        (o_filter_stride),
    .o_filter_length        (o_filter_length),
    .o_filter_bias          (o_filter_bias),
    .o_interface_write_addr (o_interface_write_addr),
    .o_interface_write_data (o_interface_write_data),
    .o_interface_write_en   (o_interface_write_en),
    .o_accel_rst            (o_accel_rst),
    .i_accel_done           (i_accel_done),
    .o_job_done             (o_job_done),
    .o_job_error            (o_job_error),
    .o_run_cycles           (o_run_cycles)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write scoreboard and job_done pulse counter
  always @(negedge i_clk) begin
    if (!i_rst && o_interface_write_en) begin
      n_wr++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'(o_interface_write_addr), 32'hFFFF_FFFF);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        chk("write_addr", 32'(o_interface_write_addr), 32'(e[33:18]));
        chk("write_data", 32'(o_interface_write_data), 32'(e[17:0]));
      end
    end
    if (!i_rst && o_job_done) n_done++;
  end

  task automatic send_word(input logic [17:0] d, input bit stall);
    bit   sent;
    logic rdy;
    sent = 0;
    for (int t = 0; t < 200 && !sent; t++) begin
      i_in_data  = d;
      i_in_valid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      rdy = o_in_ready;
      @(posedge i_clk);
      #1;
      if (i_in_valid && rdy) sent = 1;
      i_in_valid = 1'b0;
    end
    if (!sent) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_job(input logic [7:0] dim, input logic [8:0] depth,
                         input logic [15:0] io, input logic [15:0] fo, input logic [15:0] oo,
                         input logic [1:0] hs, input logic [2:0] st, input logic [12:0] fl,
                         input logic [17:0] bias, input logic [15:0] plen, input logic [15:0] pbase,
                         input int done_at, input bit stall, input int rst_at);
    logic [17:0] w [10];
    logic [17:0] d;
    bit acc;
    int done0, wr0;
    acc  = (dim != 0) && (st != 0) && (fl != 0);
    w[0] = {10'($urandom), dim};
    w[1] = {9'($urandom), depth};
    w[2] = {2'($urandom), io};
    w[3] = {2'($urandom), fo};
    w[4] = {2'($urandom), oo};
    w[5] = {13'($urandom), st, hs};
    w[6] = {5'($urandom), fl};
    w[7] = bias;
    w[8] = {2'($urandom), plen};
    w[9] = {2'($urandom), pbase};
    done0 = n_done;
    wr0   = n_wr;
    for (int i = 0; i < 10; i++) send_word(w[i], stall);
    @(negedge i_clk);
    chk("job_error", 32'(o_job_error), 32'(!acc));
    if (acc) begin
      chk("image_dim", 32'(o_image_dim), 32'(dim));
      chk("image_depth", 32'(o_image_depth), 32'(depth));
      chk("img_off", 32'(o_image_memory_offset), 32'(io));
      chk("flt_off", 32'(o_filter_memory_offset), 32'(fo));
      chk("out_off", 32'(o_output_memory_offset), 32'(oo));
      chk("halfsize", 32'(o_filter_halfsize), 32'(hs));
      chk("stride", 32'(o_filter_stride), 32'(st));
      chk("flen", 32'(o_filter_length), 32'(fl));
      chk("bias", 32'(o_filter_bias), 32'(bias));
      chk("accel_rst_after_hdr", 32'(o_accel_rst), 32'(plen != 0));
    end
    for (int k = 0; k < int'(plen); k++) begin
      d = 18'($urandom);
      if (k == rst_at) begin
        i_in_data  = d;
        i_in_valid = 1'b1;
        @(negedge i_clk);
        #1 i_rst = 1'b1;
        #1;
        chk("rst_in_ready", 32'(o_in_ready), 32'd0);
        chk("rst_accel_rst", 32'(o_accel_rst), 32'd1);
        chk("rst_wr_en", 32'(o_interface_write_en), 32'd0);
        chk("rst_wr_addr", 32'(o_interface_write_addr), 32'd0);
        chk("rst_wr_data", 32'(o_interface_write_data), 32'd0);
        chk("rst_dim", 32'(o_image_dim), 32'd0);
        chk("rst_bias", 32'(o_filter_bias), 32'd0);
        chk("rst_flen", 32'(o_filter_length), 32'd0);
        chk("rst_job_done", 32'(o_job_done), 32'd0);
        chk("rst_job_error", 32'(o_job_error), 32'd0);
        chk("rst_run_cycles", o_run_cycles, 32'd0);
        i_in_valid = 1'b0;
        @(posedge i_clk);
        #1 i_rst = 1'b0;
        @(negedge i_clk);
        chk("rst_release_ready", 32'(o_in_ready), 32'd1);
        chk("rst_wr_count", 32'(n_wr - wr0), 32'(rst_at));
        return;
      end
      if (acc) exp_q.push_back({16'(32'(pbase) + k), d});
      send_word(d, stall);
    end
    if (acc) begin
      if (plen != 0) begin
        @(negedge i_clk);
        chk("last_wr_en", 32'(o_interface_write_en), 32'd1);
        chk("run_entry_accel_rst", 32'(o_accel_rst), 32'd0);
      end
      for (int n = 1; n <= done_at; n++) begin
        i_accel_done = (n == 1) || (n == done_at);
        if (n == 2) begin
          @(negedge i_clk);
          chk("run_accel_rst", 32'(o_accel_rst), 32'd0);
          chk("run_in_ready", 32'(o_in_ready), 32'd0);
          chk("run_job_done", 32'(o_job_done), 32'd0);
        end
        @(posedge i_clk);
        #1;
      end
      i_accel_done = 1'b0;
      @(negedge i_clk);
      chk("job_done", 32'(o_job_done), 32'd1);
      chk("run_cycles", o_run_cycles, 32'(done_at));
      chk("done_accel_rst", 32'(o_accel_rst), 32'd1);
      chk("done_in_ready", 32'(o_in_ready), 32'd0);
      chk("done_bias_hold", 32'(o_filter_bias), 32'(bias));
      @(posedge i_clk);
      #1;
      @(negedge i_clk);
      chk("post_job_done", 32'(o_job_done), 32'd0);
      chk("post_in_ready", 32'(o_in_ready), 32'd1);
      chk("run_cycles_frozen", o_run_cycles, 32'(done_at));
      chk("done_count", 32'(n_done - done0), 32'd1);
    end else begin
      @(negedge i_clk);
      chk("skip_done_count", 32'(n_done - done0), 32'd0);
      chk("skip_in_ready", 32'(o_in_ready), 32'd1);
    end
    chk("wr_count", 32'(n_wr - wr0), acc ? 32'(plen) : 32'd0);
  endtask

  initial begin
    i_rst        = 1'b1;
    i_in_valid   = 1'b0;
    i_in_data    = '0;
    i_accel_done = 1'b0;
    #3;
    chk("reset_in_ready", 32'(o_in_ready), 32'd0);
    chk("reset_accel_rst", 32'(o_accel_rst), 32'd1);
    chk("reset_wr_en", 32'(o_interface_write_en), 32'd0);
    chk("reset_run_cycles", o_run_cycles, 32'd0);
    chk("reset_dim", 32'(o_image_dim), 32'd0);
    chk("reset_job_error", 32'(o_job_error), 32'd0);
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(negedge i_clk);
    chk("first_cycle_ready", 32'(o_in_ready), 32'd1);
    chk("first_cycle_job_done", 32'(o_job_done), 32'd0);

    // Reference job, accel_done glitch in first RUN cycle, real done at cycle 50
    run_job(8'd8, 9'd3, 16'h0000, 16'h00C0, 16'h0100, 2'd1, 3'd1, 13'd27, 18'd5,
            16'd4, 16'h0010, 50, 1'b0, -1);
    // Address wrap
    run_job(8'd4, 9'd2, 16'h1234, 16'h5678, 16'h9ABC, 2'd2, 3'd2, 13'd9, 18'h3FFFF,
            16'd4, 16'hFFFE, 5, 1'b1, -1);
    // Rejected header: stride zero, payload skipped
    run_job(8'd8, 9'd3, 16'h0, 16'h0, 16'h0, 2'd1, 3'd0, 13'd27, 18'd5,
            16'd3, 16'h0020, 2, 1'b1, -1);
    // Valid header with empty payload clears job_error and runs directly
    run_job(8'd16, 9'd1, 16'h0040, 16'h0080, 16'h00C0, 2'd0, 3'd3, 13'd1, 18'd7,
            16'd0, 16'h0000, 3, 1'b1, -1);
    // Stalled load
    run_job(8'd2, 9'd5, 16'h0, 16'h0, 16'h0, 2'd3, 3'd7, 13'd100, 18'd11,
            16'd6, 16'h0300, 4, 1'b1, -1);
    // Reset during payload word 2, then a full job parsed from word 0
    run_job(8'd8, 9'd3, 16'h0, 16'h00C0, 16'h0100, 2'd1, 3'd1, 13'd27, 18'd5,
            16'd4, 16'h0400, 10, 1'b0, 2);
    run_job(8'd5, 9'd6, 16'h0011, 16'h0022, 16'h0033, 2'd1, 3'd4, 13'd12, 18'd99,
            16'd3, 16'h0500, 7, 1'b1, -1);

    for (int j = 0; j < 6; j++) begin
      run_job(($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 255)),
              9'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
              2'($urandom), 3'($urandom_range(0, 7)),
              ($urandom_range(0, 4) == 0) ? 13'd0 : 13'($urandom_range(1, 8191)),
              18'($urandom), 16'($urandom_range(0, 6)), 16'($urandom),
              $urandom_range(2, 20), 1'b1, -1);
    end

    repeat (3) @(negedge i_clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
